// File: rtl/ddr_pkg.sv
// Shared timing constants, scheduler state encoding and request record
// for the DDR4 post-init command scheduler.
package ddr_pkg;

  localparam int T_RCD        = 16;
  localparam int T_RAS        = 39;
  localparam int T_RTP        = 8;
  localparam int T_WTP        = 34;
  localparam int T_RP         = 16;
  localparam int T_RFC        = 350;
  localparam int T_REFI       = 7800;
  localparam int MAX_POSTPONE = 8;

  typedef enum logic [3:0] {
    IDLE,
    ACT,
    WAIT_RCD,
    CAS,
    WAIT_PRE,
    PRE,
    WAIT_RP,
    REF,
    WAIT_RFC
  } sched_state_t;

  typedef struct packed {
    logic [1:0]  bg;
    logic [1:0]  ba;
    logic [16:0] row;
    logic [9:0]  col;
    logic        rd;
  } ddr_req_t;

endpackage

// File: rtl/ddr_ref_timer.sv
// Refresh interval counter with postponed-refresh credit, saturating at the
// ceiling, and a sticky overflow flag for ticks that arrive at the ceiling.
module ddr_ref_timer
  import ddr_pkg::*;
#(
  parameter int REFI_CYCLES = T_REFI,
  parameter int MAX_CREDIT  = MAX_POSTPONE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       ref_issue,
  output logic [3:0] credit,
  output logic       overflow,
  output logic       ref_due,
  output logic       ref_force
);

  localparam int CW = $clog2(REFI_CYCLES);

  logic [CW-1:0] refi_cnt;
  logic          wrap;
  logic          at_max;

  assign wrap      = run && (refi_cnt == CW'(REFI_CYCLES - 1));
  assign at_max    = (credit == 4'(MAX_CREDIT));
  assign ref_due   = (credit != 4'd0);
  assign ref_force = at_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refi_cnt <= '0;
      credit   <= 4'd0;
      overflow <= 1'b0;
    end else begin
      if (run) refi_cnt <= wrap ? '0 : refi_cnt + CW'(1);
      if (wrap && at_max) overflow <= 1'b1;
      // A tick and an issue in the same cycle cancel out.
      if (wrap && !ref_issue && !at_max) credit <= credit + 4'd1;
      else if (ref_issue && !wrap && ref_due) credit <= credit - 4'd1;
    end
  end

endmodule

// File: rtl/ddr_cmd_sched.sv
// Closed-page DDR4 command scheduler: ACT -> RD/WR -> PRE per request, with
// interleaved all-bank refresh. Define AUTO_PRECHARGE_EN for RD/WR with A10 set.
module ddr_cmd_sched
  import ddr_pkg::*;
#(
  parameter int REFI_CYCLES = T_REFI
) (
  input  logic         CK_t,
  input  logic         reset,
  input  logic         ini_done,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_rd,
  input  logic [1:0]   req_bg,
  input  logic [1:0]   req_ba,
  input  logic [16:0]  req_row,
  input  logic [9:0]   req_col,
  output logic         act_rdy,
  output logic         rd_rdy,
  output logic         wr_rdy,
  output logic         pre_rdy,
  output logic         ref_rdy,
  output logic         des_rdy,
  output logic [1:0]   cmd_bg,
  output logic [1:0]   cmd_ba,
  output logic [16:0]  cmd_row,
  output logic [9:0]   cmd_col,
  output logic         cmd_ap,
  output logic [3:0]   ref_credit,
  output logic         ref_overflow,
  output sched_state_t fsm_state
);

  // Request handshake: a request transfers on every rising edge where
  // req_valid and req_ready are both high; req_ready is combinational, only
  // high in IDLE with no refresh selected, and never depends on the past of
  // req_valid, so a master may hold or drop valid freely.

  sched_state_t state, state_n;
  ddr_req_t     req_q, req_n;
  logic         active_q, run;
  logic         ref_due, ref_force, ref_sel, ref_go, accept;
  logic [15:0]  act_cnt, cas_cnt, wait_cnt, t_cp;
  logic         pre_ok, rp_done, addr_vis, strobe_n;

  assign run       = active_q | ini_done;
  assign ref_sel   = ref_force | (ref_due & ~req_valid);
  assign req_ready = !reset && run && (state == IDLE) && !ref_sel;
  assign accept    = req_valid && req_ready;
  assign ref_go    = run && (state == IDLE) && ref_sel;
  assign fsm_state = state;

  assign t_cp   = req_q.rd ? 16'(T_RTP) : 16'(T_WTP);
  assign pre_ok = (act_cnt + 16'd1 >= 16'(T_RAS)) && (cas_cnt + 16'd1 >= t_cp);
`ifdef AUTO_PRECHARGE_EN
  // Implicit precharge lands where an explicit PRE would; IDLE follows T_RP later.
  assign rp_done = (act_cnt + 16'd1 >= 16'(T_RAS + T_RP)) &&
                   (cas_cnt + 16'd1 >= t_cp + 16'(T_RP));
`else
  assign rp_done = (wait_cnt == 16'(T_RP - 1));
`endif

  always_comb begin
    req_n = req_q;
    if (accept) req_n = '{bg: req_bg, ba: req_ba, row: req_row, col: req_col, rd: req_rd};
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (ref_go) state_n = REF;
                else if (accept) state_n = ACT;
      ACT:      state_n = WAIT_RCD;
      WAIT_RCD: if (act_cnt == 16'(T_RCD - 1)) state_n = CAS;
`ifdef AUTO_PRECHARGE_EN
      CAS:      state_n = WAIT_RP;
`else
      CAS:      state_n = WAIT_PRE;
`endif
      WAIT_PRE: if (pre_ok) state_n = PRE;
      PRE:      state_n = WAIT_RP;
      WAIT_RP:  if (rp_done) state_n = IDLE;
      REF:      state_n = WAIT_RFC;
      WAIT_RFC: if (wait_cnt == 16'(T_RFC - 1)) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  assign addr_vis = state_n inside {ACT, WAIT_RCD, CAS, WAIT_PRE, PRE};
  assign strobe_n = state_n inside {ACT, CAS, PRE, REF};

  // Strobes and address are registered from the next state so they line up
  // with the cycle the FSM spends in the command state.
  always_ff @(posedge CK_t or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      active_q <= 1'b0;
      req_q    <= '0;
      act_cnt  <= 16'd0;
      cas_cnt  <= 16'd0;
      wait_cnt <= 16'd0;
      act_rdy  <= 1'b0;
      rd_rdy   <= 1'b0;
      wr_rdy   <= 1'b0;
      pre_rdy  <= 1'b0;
      ref_rdy  <= 1'b0;
      des_rdy  <= 1'b0;
      cmd_bg   <= 2'd0;
      cmd_ba   <= 2'd0;
      cmd_row  <= 17'd0;
      cmd_col  <= 10'd0;
    end else begin
      state    <= state_n;
      active_q <= active_q | ini_done;
      req_q    <= req_n;
      act_cnt  <= (state == ACT) ? 16'd1 : act_cnt + 16'd1;
      cas_cnt  <= (state == CAS) ? 16'd1 : cas_cnt + 16'd1;
      wait_cnt <= (state == PRE || state == REF) ? 16'd1 : wait_cnt + 16'd1;
      act_rdy  <= (state_n == ACT);
      rd_rdy   <= (state_n == CAS) && req_n.rd;
      wr_rdy   <= (state_n == CAS) && !req_n.rd;
      pre_rdy  <= (state_n == PRE);
      ref_rdy  <= (state_n == REF);
      des_rdy  <= run && !strobe_n;
      cmd_bg   <= addr_vis ? req_n.bg  : 2'd0;
      cmd_ba   <= addr_vis ? req_n.ba  : 2'd0;
      cmd_row  <= addr_vis ? req_n.row : 17'd0;
      cmd_col  <= addr_vis ? req_n.col : 10'd0;
    end
  end

`ifdef AUTO_PRECHARGE_EN
  always_ff @(posedge CK_t or posedge reset) begin
    if (reset) cmd_ap <= 1'b0;
    else       cmd_ap <= (state_n == CAS);
  end
`else
  assign cmd_ap = 1'b0;
`endif

  ddr_ref_timer #(
    .REFI_CYCLES (REFI_CYCLES),
    .MAX_CREDIT  (MAX_POSTPONE)
  ) u_ref_timer (
    .clk       (CK_t),
    .rst       (reset),
    .run       (run),
    .ref_issue (ref_go),
    .credit    (ref_credit),
    .overflow  (ref_overflow),
    .ref_due   (ref_due),
    .ref_force (ref_force)
  );

endmodule

// File: tb/tb_ddr_cmd_sched.sv
// Scoreboard bench for ddr_cmd_sched: directed requests push expected command
// records; a negedge monitor pops and compares each issued command.
module tb_ddr_cmd_sched;
  import ddr_pkg::*;

  localparam int W = 67;
  localparam logic [2:0] K_ACT = 3'd1, K_RD = 3'd2, K_WR = 3'd3, K_PRE = 3'd4, K_REF = 3'd5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic        ini_done, req_valid, req_ready, req_rd;
  logic [1:0]  req_bg, req_ba;
  logic [16:0] req_row;
  logic [9:0]  req_col;
  logic        act_rdy, rd_rdy, wr_rdy, pre_rdy, ref_rdy, des_rdy;
  logic [1:0]  cmd_bg, cmd_ba;
  logic [16:0] cmd_row;
  logic [9:0]  cmd_col;
  logic        cmd_ap;
  logic [3:0]  ref_credit;
  logic        ref_overflow;
  sched_state_t fsm_state;
  logic [5:0]  strobes;
  assign strobes = {act_rdy, rd_rdy, wr_rdy, pre_rdy, ref_rdy, des_rdy};

  ddr_cmd_sched dut (
    .CK_t(clk), .reset(reset), .ini_done(ini_done),
    .req_valid(req_valid), .req_ready(req_ready), .req_rd(req_rd),
    .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row), .req_col(req_col),
    .act_rdy(act_rdy), .rd_rdy(rd_rdy), .wr_rdy(wr_rdy), .pre_rdy(pre_rdy),
    .ref_rdy(ref_rdy), .des_rdy(des_rdy),
    .cmd_bg(cmd_bg), .cmd_ba(cmd_ba), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .cmd_ap(cmd_ap), .ref_credit(ref_credit), .ref_overflow(ref_overflow),
    .fsm_state(fsm_state)
  );

  // Short refresh interval instance so the credit ceiling is reachable quickly.
  logic        ini_ov = 1'b0;
  logic        ready_ov, act_ov, rd_ov, wr_ov, pre_ov, ref_ov, des_ov, ap_ov, ovf_ov;
  logic [1:0]  bg_ov, ba_ov;
  logic [16:0] row_ov;
  logic [9:0]  col_ov;
  logic [3:0]  credit_ov;
  sched_state_t state_ov;

  ddr_cmd_sched #(.REFI_CYCLES(100)) dut_ov (
    .CK_t(clk), .reset(reset), .ini_done(ini_ov),
    .req_valid(1'b0), .req_ready(ready_ov), .req_rd(1'b0),
    .req_bg(2'd0), .req_ba(2'd0), .req_row(17'd0), .req_col(10'd0),
    .act_rdy(act_ov), .rd_rdy(rd_ov), .wr_rdy(wr_ov), .pre_rdy(pre_ov),
    .ref_rdy(ref_ov), .des_rdy(des_ov),
    .cmd_bg(bg_ov), .cmd_ba(ba_ov), .cmd_row(row_ov), .cmd_col(col_ov),
    .cmd_ap(ap_ov), .ref_credit(credit_ov), .ref_overflow(ovf_ov),
    .fsm_state(state_ov)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  logic ov_done = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [2:0] k, input int c, input logic [1:0] bg,
                                      input logic [1:0] ba, input logic [16:0] row,
                                      input logic [9:0] col);
    return {k, 32'(c), bg, ba, row, col, 1'b0};
  endfunction

  always @(negedge clk) begin
    logic [2:0]   k;
    logic [W-1:0] a, e;
    if (strobes[5:1] != 5'd0) begin
      check("cmd_one_hot", W'($countones(strobes[5:1])), W'(1));
      check("cmd_des_low", W'(des_rdy), W'(0));
      k = act_rdy ? K_ACT : rd_rdy ? K_RD : wr_rdy ? K_WR : pre_rdy ? K_PRE : K_REF;
      a = {k, 32'(cyc), cmd_bg, cmd_ba, cmd_row, cmd_col, cmd_ap};
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_cmd at cycle %0d: got kind %0d, expected none", cyc, k);
      end else begin
        e = exp_q.pop_front();
        check("cmd_kind", W'(a[W-1 -: 3]), W'(e[W-1 -: 3]));
        check("cmd_cycle", W'(a[W-4 -: 32]), W'(e[W-4 -: 32]));
        check("cmd_fields", W'(a[31:0]), W'(e[31:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_ready(output int c);
    int k;
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout at cycle %0d: got req_ready 0, expected 1", cyc);
    end
    c = cyc;
  endtask

  // Hand-computed offsets from accept: ACT +1, CAS +17, PRE +40 (rd) / +51 (wr).
  task automatic issue_req(input string name, input logic rd, input logic [1:0] bg,
                           input logic [1:0] ba, input logic [16:0] row,
                           input logic [9:0] col, output int acc);
    req_rd = rd; req_bg = bg; req_ba = ba; req_row = row; req_col = col;
    req_valid = 1'b1;
    #1;
    check(name, W'(req_ready), W'(1));
    acc = cyc;
    exp_q.push_back(mk(K_ACT, acc + 1, bg, ba, row, col));
    exp_q.push_back(mk(rd ? K_RD : K_WR, acc + 17, bg, ba, row, col));
    exp_q.push_back(mk(K_PRE, acc + (rd ? 40 : 51), bg, ba, row, col));
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    int t0, acc, c, e, refs, i;
    logic rd, done;
    ini_done = 1'b0; req_valid = 1'b0; req_rd = 1'b0;
    req_bg = 2'd0; req_ba = 2'd0; req_row = 17'd0; req_col = 10'd0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", W'({req_ready, strobes, cmd_bg, cmd_ba, cmd_row, cmd_col, cmd_ap,
                               ref_credit, ref_overflow, fsm_state}), W'(0));
    reset = 1'b0;

    // Before init completes the scheduler must stay silent.
    req_valid = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      check("pre_init_quiet", W'({req_ready, strobes, ref_credit}), W'(0));
    end
    req_valid = 1'b0;

    @(negedge clk);
    t0 = cyc;
    ini_done = 1'b1;
    issue_req("rd_accept", 1'b1, 2'd1, 2'd2, 17'h1abcd, 10'h155, acc);
    @(negedge clk);
    req_valid = 1'b0;
    wait_ready(c);
    check("rd_ready_again", W'(c - acc), W'(56));
    check("idle_des", W'(des_rdy), W'(1));

    issue_req("wr_accept", 1'b0, 2'd3, 2'd0, 17'h00f0f, 10'h2aa, acc);
    @(negedge clk);
    req_valid = 1'b0;
    wait_ready(c);
    check("wr_ready_again", W'(c - acc), W'(67));

    // First refresh interval expires with an idle bus.
    exp_q.push_back(mk(K_REF, t0 + 7801, 2'd0, 2'd0, 17'd0, 10'd0));
    wait_until(t0 + 7800);
    check("refi_credit_one", W'(ref_credit), W'(1));
    check("refi_ready_low", W'(req_ready), W'(0));
    @(negedge clk);
    check("ref_credit_zero", W'(ref_credit), W'(0));
    wait_until(t0 + 7801 + 349);
    check("rfc_ready_low", W'(req_ready), W'(0));
    @(negedge clk);
    check("rfc_ready_high", W'(req_ready), W'(1));

    // Back-to-back traffic until eight postponed refreshes force a REF.
    wait_until(t0 + 8200);
    refs = 1;
    i = 0;
    done = 1'b0;
    while (!done) begin
      rd = (i % 3) != 0;
      issue_req("b2b_accept", rd, 2'(i), 2'(i / 4), 17'(i * 37 + 5), 10'(i * 11), acc);
      e = acc + (rd ? 56 : 67);
      @(negedge clk);
      wait_until(e);
      if ((e - t0) / 7800 - refs >= 8) begin
        #1;
        check("force_credit", W'(ref_credit), W'(8));
        check("force_ready_low", W'(req_ready), W'(0));
        exp_q.push_back(mk(K_REF, e + 1, 2'd0, 2'd0, 17'd0, 10'd0));
        done = 1'b1;
      end
      i++;
    end
    check("b2b_no_overflow", W'(ref_overflow), W'(0));

    // Reset in the middle of the refresh wait.
    wait_until(e + 101);
    check("mid_rfc_state", W'(fsm_state), W'(WAIT_RFC));
    #2 reset = 1'b1;
    req_valid = 1'b0;
    #1;
    check("reset_abort_outputs", W'({req_ready, strobes, cmd_bg, cmd_ba, cmd_row, cmd_col, cmd_ap,
                                     ref_credit, ref_overflow, fsm_state}), W'(0));
    check("queue_drained_at_reset", W'(exp_q.size()), W'(0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    issue_req("post_reset_accept", 1'b1, 2'd2, 2'd1, 17'h10001, 10'h3ff, acc);
    @(negedge clk);
    req_valid = 1'b0;
    wait_ready(c);
    check("post_reset_ready", W'(c - acc), W'(56));
    check("queue_drained_end", W'(exp_q.size()), W'(0));

    while (!ov_done) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Credit ceiling and sticky overflow on the short-interval instance.
  initial begin
    int max_cr;
    max_cr = 0;
    wait (reset == 1'b1);
    wait (reset == 1'b0);
    @(negedge clk);
    ini_ov = 1'b1;
    for (int k = 0; k < 20000 && !ovf_ov; k++) begin
      @(negedge clk);
      if (int'(credit_ov) > max_cr) max_cr = int'(credit_ov);
    end
    check("ov_set", W'(ovf_ov), W'(1));
    check("ov_credit_at_ceiling", W'(credit_ov), W'(8));
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (int'(credit_ov) > max_cr) max_cr = int'(credit_ov);
    end
    check("ov_sticky", W'(ovf_ov), W'(1));
    check("ov_credit_max", W'(max_cr), W'(8));
    ov_done = 1'b1;
  end

endmodule
